// File: rtl/job_control.sv
// PSL job-control engine: decodes ha_j* commands and sequences reset, start, run and
// completion. Done/ack events pass through a DONE_DELAY-stage pipeline.
module job_control #(
  parameter int unsigned DONE_DELAY   = 1,
  parameter int unsigned RESET_CYCLES = 4,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic        ha_pclock,
  input  logic        reset,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        ha_jeapar,
  input  logic        app_done,
  input  logic [0:63] app_error,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield,
  output logic        afu_reset,
  output logic        job_start,
  output logic [0:63] job_ea,
  output logic        parity_err
);

  localparam logic [0:7] CMD_RESET = 8'h80;
  localparam logic [0:7] CMD_START = 8'h90;
  localparam logic [0:7] CMD_LLCMD = 8'h45;

  typedef enum logic [1:0] {IDLE, RESETTING, READY, RUNNING} state_t;

  state_t            state_q, state_d;
  logic [7:0]        rst_cnt_q, rst_cnt_d;
  logic              afu_reset_q, afu_reset_d;
  logic              running_q, running_d;
  logic              job_start_q, job_start_d;
  logic [0:63]       job_ea_q, job_ea_d;
  logic [0:63]       jerror_q, jerror_d;
  logic              parity_err_q, parity_err_d;
  logic [DONE_DELAY:0] done_pipe_q, done_pipe_d;
  logic [DONE_DELAY:0] ack_pipe_q, ack_pipe_d;

  logic par_fault, cmd_ok, rst_cmd, start_cmd, ll_cmd, done_ev, ack_ev;

  always_comb begin
    par_fault = PARITY_CHECK && ha_jval &&
                ((ha_jcompar != ~^ha_jcom) ||
                 ((ha_jcom == CMD_START) && (ha_jeapar != ~^ha_jea)));
    cmd_ok    = ha_jval && !par_fault;
    rst_cmd   = cmd_ok && (ha_jcom == CMD_RESET);
    start_cmd = cmd_ok && (ha_jcom == CMD_START);
    ll_cmd    = cmd_ok && (ha_jcom == CMD_LLCMD);

    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    afu_reset_d  = afu_reset_q;
    running_d    = running_q;
    job_start_d  = 1'b0;
    job_ea_d     = job_ea_q;
    jerror_d     = jerror_q;
    parity_err_d = parity_err_q | par_fault;
    done_ev      = 1'b0;
    ack_ev       = 1'b0;

    // RESET overrides everything, including an app_done in the same cycle
    if (rst_cmd) begin
      state_d     = RESETTING;
      rst_cnt_d   = 8'(RESET_CYCLES);
      afu_reset_d = 1'b1;
      running_d   = 1'b0;
      jerror_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: afu_reset_d = 1'b1;
        RESETTING: begin
          if (rst_cnt_q == 8'd0) begin
            state_d     = READY;
            afu_reset_d = 1'b0;
            done_ev     = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q - 8'd1;
          end
        end
        READY: begin
          if (start_cmd) begin
            state_d     = RUNNING;
            job_ea_d    = ha_jea;
            job_start_d = 1'b1;
            running_d   = 1'b1;
          end
        end
        RUNNING: begin
          ack_ev = ll_cmd;
          if (app_done) begin
            state_d     = IDLE;
            running_d   = 1'b0;
            afu_reset_d = 1'b1;
            jerror_d    = app_error;
            done_ev     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Bit 0 holds the newest event; the top bit drives the output
    done_pipe_d    = done_pipe_q << 1;
    done_pipe_d[0] = done_ev;
    ack_pipe_d     = ack_pipe_q << 1;
    ack_pipe_d[0]  = ack_ev;
    if (rst_cmd) begin
      done_pipe_d = '0;
      ack_pipe_d  = '0;
    end
  end

  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      afu_reset_q  <= 1'b1;
      running_q    <= 1'b0;
      job_start_q  <= 1'b0;
      job_ea_q     <= '0;
      jerror_q     <= '0;
      parity_err_q <= 1'b0;
      done_pipe_q  <= '0;
      ack_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      afu_reset_q  <= afu_reset_d;
      running_q    <= running_d;
      job_start_q  <= job_start_d;
      job_ea_q     <= job_ea_d;
      jerror_q     <= jerror_d;
      parity_err_q <= parity_err_d;
      done_pipe_q  <= done_pipe_d;
      ack_pipe_q   <= ack_pipe_d;
    end
  end

  assign ah_jrunning = running_q;
  assign ah_jdone    = done_pipe_q[DONE_DELAY];
  assign ah_jcack    = ack_pipe_q[DONE_DELAY];
  assign ah_jerror   = jerror_q;
  assign ah_jyield   = 1'b0;
  assign afu_reset   = afu_reset_q;
  assign job_start   = job_start_q;
  assign job_ea      = job_ea_q;
  assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_job_control.sv
// Directed bench for job_control: u_dut (defaults) and u_np (DONE_DELAY=0, parity
// checking off) share all inputs.
module tb_job_control;

  logic        ha_pclock = 1'b0;
  logic        reset;
  logic        ha_jval;
  logic [0:7]  ha_jcom;
  logic        ha_jcompar;
  logic [0:63] ha_jea;
  logic        ha_jeapar;
  logic        app_done;
  logic [0:63] app_error;

  logic        ah_jrunning, ah_jdone, ah_jcack, ah_jyield, afu_reset, job_start, parity_err;
  logic [0:63] ah_jerror, job_ea;
  logic        np_jrunning, np_jdone, np_jcack, np_jyield, np_afu_reset, np_job_start, np_parity_err;
  logic [0:63] np_jerror, np_job_ea;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 ha_pclock = ~ha_pclock;

  job_control #(.DONE_DELAY(1), .RESET_CYCLES(4), .PARITY_CHECK(1'b1)) u_dut (
    .ha_pclock(ha_pclock), .reset(reset), .ha_jval(ha_jval), .ha_jcom(ha_jcom),
    .ha_jcompar(ha_jcompar), .ha_jea(ha_jea), .ha_jeapar(ha_jeapar),
    .app_done(app_done), .app_error(app_error), .ah_jrunning(ah_jrunning),
    .ah_jdone(ah_jdone), .ah_jcack(ah_jcack), .ah_jerror(ah_jerror),
    .ah_jyield(ah_jyield), .afu_reset(afu_reset), .job_start(job_start),
    .job_ea(job_ea), .parity_err(parity_err)
  );

  job_control #(.DONE_DELAY(0), .RESET_CYCLES(4), .PARITY_CHECK(1'b0)) u_np (
    .ha_pclock(ha_pclock), .reset(reset), .ha_jval(ha_jval), .ha_jcom(ha_jcom),
    .ha_jcompar(ha_jcompar), .ha_jea(ha_jea), .ha_jeapar(ha_jeapar),
    .app_done(app_done), .app_error(app_error), .ah_jrunning(np_jrunning),
    .ah_jdone(np_jdone), .ah_jcack(np_jcack), .ah_jerror(np_jerror),
    .ah_jyield(np_jyield), .afu_reset(np_afu_reset), .job_start(np_job_start),
    .job_ea(np_job_ea), .parity_err(np_parity_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ha_pclock);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] c, input logic [63:0] ea, input logic flip_ea);
    ha_jval    = 1'b1;
    ha_jcom    = c;
    ha_jcompar = ~^c;
    ha_jea     = ea;
    ha_jeapar  = (~^ea) ^ flip_ea;
  endtask

  task automatic idle_cmd();
    ha_jval = 1'b0;
    ha_jcom = '0;
    ha_jea  = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; ha_jval = 1'b0; ha_jcom = '0; ha_jcompar = 1'b0;
    ha_jea = '0; ha_jeapar = 1'b0; app_done = 1'b0; app_error = '0;
    step(); step();
    check_eq("rst_afu_reset", 64'(afu_reset), 64'd1);
    check_eq("rst_running", 64'(ah_jrunning), 64'd0);
    check_eq("rst_jdone", 64'(ah_jdone), 64'd0);
    check_eq("rst_jerror", ah_jerror, 64'd0);
    check_eq("rst_parity_err", 64'(parity_err), 64'd0);
    check_eq("rst_jyield", 64'(ah_jyield), 64'd0);
    reset = 1'b0;
    step(); step();
    check_eq("idle_afu_reset", 64'(afu_reset), 64'd1);

    // RESET command: afu_reset held 4 cycles after the command edge, done one later
    drive_cmd(8'h80, 64'd0, 1'b0); step(); idle_cmd();
    check_eq("rcmd_afu_reset_e0", 64'(afu_reset), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("rcmd_afu_reset_hold", 64'(afu_reset), 64'd1);
      check_eq("rcmd_jdone_early", 64'(ah_jdone), 64'd0);
    end
    step();
    check_eq("rcmd_afu_reset_drop", 64'(afu_reset), 64'd0);
    check_eq("rcmd_jdone_e5", 64'(ah_jdone), 64'd0);
    check_eq("np_jdone_dd0_e5", 64'(np_jdone), 64'd1);
    step();
    check_eq("rcmd_jdone_e6", 64'(ah_jdone), 64'd1);
    check_eq("np_jdone_dd0_e6", 64'(np_jdone), 64'd0);
    step();
    check_eq("rcmd_jdone_e7", 64'(ah_jdone), 64'd0);

    // START
    drive_cmd(8'h90, 64'h0000_0000_1234_5000, 1'b0); step(); idle_cmd();
    check_eq("start_pulse", 64'(job_start), 64'd1);
    check_eq("start_ea", job_ea, 64'h0000_0000_1234_5000);
    check_eq("start_running", 64'(ah_jrunning), 64'd1);
    step();
    check_eq("start_pulse_end", 64'(job_start), 64'd0);
    check_eq("start_running_hold", 64'(ah_jrunning), 64'd1);

    // two back-to-back LLCMDs
    drive_cmd(8'h45, 64'd0, 1'b0); step();
    check_eq("ll_cack_l1", 64'(ah_jcack), 64'd0);
    step(); idle_cmd();
    check_eq("ll_cack_a", 64'(ah_jcack), 64'd1);
    step();
    check_eq("ll_cack_b", 64'(ah_jcack), 64'd1);
    step();
    check_eq("ll_cack_end", 64'(ah_jcack), 64'd0);
    check_eq("ll_running", 64'(ah_jrunning), 64'd1);

    // app_done completes the job
    app_done = 1'b1; app_error = 64'h2A; step(); app_done = 1'b0; app_error = '0;
    check_eq("done_running", 64'(ah_jrunning), 64'd0);
    check_eq("done_jerror", ah_jerror, 64'h2A);
    check_eq("done_jdone_e0", 64'(ah_jdone), 64'd0);
    step();
    check_eq("done_jdone_e1", 64'(ah_jdone), 64'd1);
    step();
    check_eq("done_jdone_e2", 64'(ah_jdone), 64'd0);
    check_eq("done_jerror_held", ah_jerror, 64'h2A);

    // START without a preceding RESET is ignored
    drive_cmd(8'h90, 64'h0000_0000_1234_5000, 1'b0); step(); idle_cmd();
    check_eq("idle_start_ign", 64'(job_start), 64'd0);
    check_eq("idle_start_run", 64'(ah_jrunning), 64'd0);

    // RESET back to READY; clears ah_jerror
    drive_cmd(8'h80, 64'd0, 1'b0); step(); idle_cmd();
    check_eq("rcmd2_jerror_clr", ah_jerror, 64'd0);
    repeat (5) step();
    check_eq("rcmd2_ready", 64'(afu_reset), 64'd0);
    step(); step();

    // LLCMD in READY: no ack
    drive_cmd(8'h45, 64'd0, 1'b0); step(); step(); idle_cmd();
    check_eq("ready_ll_a", 64'(ah_jcack), 64'd0);
    step();
    check_eq("ready_ll_b", 64'(ah_jcack), 64'd0);
    step();
    check_eq("ready_ll_c", 64'(ah_jcack), 64'd0);

    drive_cmd(8'h90, 64'hDEAD_BEEF_0000_1000, 1'b0); step(); idle_cmd();
    check_eq("start2_running", 64'(ah_jrunning), 64'd1);
    check_eq("start2_ea", job_ea, 64'hDEAD_BEEF_0000_1000);
    step();

    // RESET and app_done in the same cycle
    drive_cmd(8'h80, 64'd0, 1'b0); app_done = 1'b1; app_error = 64'h55;
    step(); idle_cmd(); app_done = 1'b0; app_error = '0;
    check_eq("sim_running", 64'(ah_jrunning), 64'd0);
    check_eq("sim_jerror", ah_jerror, 64'd0);
    check_eq("sim_afu_reset", 64'(afu_reset), 64'd1);
    step();
    check_eq("sim_no_app_jdone", 64'(ah_jdone), 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ah_jdone) n++;
    end
    check_eq("sim_jdone_count", 64'(n), 64'd1);

    // START with bad ha_jeapar: dropped when checked, accepted when not
    drive_cmd(8'h90, 64'h0000_0000_0000_0ABC, 1'b1); step(); idle_cmd();
    check_eq("par_no_start", 64'(job_start), 64'd0);
    check_eq("par_err_set", 64'(parity_err), 64'd1);
    check_eq("np_par_start", 64'(np_job_start), 64'd1);
    check_eq("np_par_err", 64'(np_parity_err), 64'd0);
    step(); step();
    check_eq("par_err_sticky", 64'(parity_err), 64'd1);
    check_eq("par_not_running", 64'(ah_jrunning), 64'd0);
    check_eq("np_par_running", 64'(np_jrunning), 64'd1);

    drive_cmd(8'h90, 64'h0000_0000_0000_0ABC, 1'b0); step(); idle_cmd();
    check_eq("par_good_start", 64'(job_start), 64'd1);
    check_eq("par_err_still", 64'(parity_err), 64'd1);
    check_eq("np_start_ign_running", 64'(np_job_start), 64'd0);

    reset = 1'b1; step(); reset = 1'b0;
    check_eq("rst2_parity_clr", 64'(parity_err), 64'd0);
    check_eq("rst2_running", 64'(ah_jrunning), 64'd0);
    check_eq("rst2_afu_reset", 64'(afu_reset), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
